// File: rtl/imem_fetch_sequencer_if.sv
// Instruction-memory bus between the fetch sequencer (master) and the
// single-port instruction RAM (slave). Read data returns one cycle after
// imemRdEn; a write is performed on the edge that samples imemWrEn.
interface imem_fetch_sequencer_if #(
  parameter int ADDR_W = 10
) ();

  logic [ADDR_W-1:0] imemAddr;
  logic              imemRdEn;
  logic              imemWrEn;
  logic [31:0]       imemWrData;
  logic [31:0]       imemRdData;

  modport master (
    output imemAddr,
    output imemRdEn,
    output imemWrEn,
    output imemWrData,
    input  imemRdData
  );

  modport slave (
    input  imemAddr,
    input  imemRdEn,
    input  imemWrEn,
    input  imemWrData,
    output imemRdData
  );

endinterface

// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer with a boot-loader write port.
// IDLE/HALTED accept loads and Start; RUN streams sequential fetches.
// A one-entry hold register keeps the visible instruction stable while the
// consumer stalls, so a read already in flight when Stall rises is kept.
module imem_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic                   clk_i,
  input  logic                   resetN_i,
  input  logic                   start_i,
  input  logic                   stall_i,
  input  logic                   branchTaken_i,
  input  logic [31:0]            branchTarget_i,
  input  logic                   halt_i,
  input  logic                   loadReq_i,
  input  logic [ADDR_W-1:0]      loadAddr_i,
  input  logic [31:0]            loadData_i,
  output logic                   loadGrant_o,
  output logic [31:0]            instrOut_o,
  output logic [31:0]            pcOut_o,
  output logic                   instrValid_o,
  output logic                   busy_o,
  imem_fetch_sequencer_if.master imem
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        rdPend_q, rdPend_d;
  logic [31:0] rdPc_q, rdPc_d;
  logic [31:0] holdInstr_q, holdInstr_d;
  logic [31:0] holdPc_q, holdPc_d;
  logic        holdValid_q, holdValid_d;
  logic        issue;
  logic        grant;
  logic        unusedTargetBits;

  // Branch targets are forced word-aligned, so the low bits are dropped.
  assign unusedTargetBits = ^branchTarget_i[1:0];

  // Next-state, fetch issue and load grant decisions for the current cycle.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rdPend_d    = 1'b0;
    rdPc_d      = rdPc_q;
    holdInstr_d = holdInstr_q;
    holdPc_d    = holdPc_q;
    holdValid_d = holdValid_q;
    issue       = 1'b0;
    grant       = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        grant = loadReq_i;
        if (!loadReq_i && start_i) begin
          state_d     = RUN;
          pc_d        = RESET_PC;
          holdValid_d = 1'b0;
        end
      end
      RUN: begin
        if (rdPend_q) begin
          holdInstr_d = imem.imemRdData;
          holdPc_d    = rdPc_q;
          holdValid_d = 1'b1;
        end
        if (halt_i) begin
          state_d     = HALTED;
          holdValid_d = 1'b0;
        end else if (branchTaken_i) begin
          pc_d        = {branchTarget_i[31:2], 2'b00};
          holdValid_d = 1'b0;
        end else if (!stall_i) begin
          issue       = 1'b1;
          pc_d        = pc_q + 32'd4;
          rdPend_d    = 1'b1;
          rdPc_d      = pc_q;
          holdValid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!resetN_i) begin
      issue = 1'b0;
      grant = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!resetN_i) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      rdPend_q    <= 1'b0;
      rdPc_q      <= 32'd0;
      holdInstr_q <= 32'd0;
      holdPc_q    <= 32'd0;
      holdValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rdPend_q    <= rdPend_d;
      rdPc_q      <= rdPc_d;
      holdInstr_q <= holdInstr_d;
      holdPc_q    <= holdPc_d;
      holdValid_q <= holdValid_d;
    end
  end

  assign imem.imemRdEn   = issue;
  assign imem.imemWrEn   = grant;
  assign imem.imemAddr   = grant ? loadAddr_i : pc_q[ADDR_W+1:2];
  assign imem.imemWrData = loadData_i;

  assign loadGrant_o  = grant;
  assign busy_o       = (state_q == RUN);
  assign instrValid_o = (state_q == RUN) && (rdPend_q || holdValid_q);
  assign instrOut_o   = rdPend_q ? imem.imemRdData : holdInstr_q;
  assign pcOut_o      = rdPend_q ? rdPc_q : holdPc_q;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Self-checking bench for imem_fetch_sequencer: directed scenarios with
// literal expectations, then randomized traffic against a queue-based model.
module tb_imem_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        resetN, start, stall, branch, halt, loadReq;
  logic [31:0] target, loadData;
  logic [9:0]  loadAddr;
  logic        loadGrant, instrValid, busy;
  logic [31:0] instrOut, pcOut;

  int testsRun    = 0;
  int testsFailed = 0;
  bit checkEn     = 1'b0;

  logic [31:0] mem    [1024];
  logic [31:0] refMem [1024];
  logic [31:0] aWord  [5];

  bit          mRunning;
  logic [31:0] mPc;
  logic [31:0] fetchQ[$];
  logic [31:0] frontPc;
  bit          expRd, expGrant, expValid;

  imem_fetch_sequencer_if #(.ADDR_W(10)) bus ();

  imem_fetch_sequencer #(.RESET_PC(RESET_PC), .ADDR_W(10)) dut (
    .clk_i          (clk),
    .resetN_i       (resetN),
    .start_i        (start),
    .stall_i        (stall),
    .branchTaken_i  (branch),
    .branchTarget_i (target),
    .halt_i         (halt),
    .loadReq_i      (loadReq),
    .loadAddr_i     (loadAddr),
    .loadData_i     (loadData),
    .loadGrant_o    (loadGrant),
    .instrOut_o     (instrOut),
    .pcOut_o        (pcOut),
    .instrValid_o   (instrValid),
    .busy_o         (busy),
    .imem           (bus)
  );

  always #5 clk = ~clk;

  // Instruction RAM: synchronous write, one-cycle read latency.
  always @(posedge clk) begin
    if (bus.imemWrEn) mem[bus.imemAddr] = bus.imemWrData;
    if (bus.imemRdEn) bus.imemRdData <= mem[bus.imemAddr];
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %08h expected %08h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b expected %b at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rn, input logic st, input logic sl, input logic br,
                               input logic [31:0] tg, input logic hl, input logic lr,
                               input logic [9:0] la, input logic [31:0] ld);
    @(posedge clk);
    #1;
    resetN   = rn;
    start    = st;
    stall    = sl;
    branch   = br;
    target   = tg;
    halt     = hl;
    loadReq  = lr;
    loadAddr = la;
    loadData = ld;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
  endtask

  task automatic sampleNow();
    @(negedge clk);
    #1;
  endtask

  // Reference model: check this cycle's outputs, then advance on its inputs.
  always @(negedge clk) begin
    expRd    = mRunning && !halt && !branch && !stall;
    expGrant = !mRunning && loadReq;
    expValid = mRunning && (fetchQ.size() > 0);
    if (checkEn) begin
      if (!resetN) begin
        checkBit("rstRdEn", bus.imemRdEn, 1'b0);
        checkBit("rstWrEn", bus.imemWrEn, 1'b0);
        checkBit("rstGrant", loadGrant, 1'b0);
      end else begin
        checkBit("rdEn", bus.imemRdEn, expRd);
        checkBit("wrEn", bus.imemWrEn, expGrant);
        checkBit("loadGrant", loadGrant, expGrant);
        checkBit("busy", busy, mRunning);
        checkBit("instrValid", instrValid, expValid);
        checkBit("rdWrExclusive", bus.imemRdEn && bus.imemWrEn, 1'b0);
        if (expRd) checkOutput("fetchAddr", 32'(bus.imemAddr), 32'(mPc[11:2]));
        if (expGrant) begin
          checkOutput("loadAddr", 32'(bus.imemAddr), 32'(loadAddr));
          checkOutput("loadData", bus.imemWrData, loadData);
        end
        if (expValid) begin
          frontPc = fetchQ[0];
          checkOutput("instrOut", instrOut, refMem[frontPc[11:2]]);
          checkOutput("pcOut", pcOut, frontPc);
        end
      end
    end
    if (!resetN) begin
      mRunning = 1'b0;
      mPc      = RESET_PC;
      fetchQ.delete();
    end else if (!mRunning) begin
      if (loadReq) begin
        refMem[loadAddr] = loadData;
      end else if (start) begin
        mRunning = 1'b1;
        mPc      = RESET_PC;
        fetchQ.delete();
      end
    end else begin
      if (fetchQ.size() > 0 && (!stall || halt || branch)) void'(fetchQ.pop_front());
      if (halt) begin
        mRunning = 1'b0;
        fetchQ.delete();
      end else if (branch) begin
        mPc = {target[31:2], 2'b00};
      end else if (!stall) begin
        fetchQ.push_back(mPc);
        mPc = mPc + 32'd4;
      end
    end
  end

  // Directed scenarios with literal expectations, then randomized traffic.
  initial begin
    resetN = 1'b0; start = 1'b0; stall = 1'b0; branch = 1'b0; target = 32'd0;
    halt = 1'b0; loadReq = 1'b0; loadAddr = 10'd0; loadData = 32'd0;
    aWord = '{32'h1111_00A0, 32'h2222_00A1, 32'h3333_00A2, 32'h4444_00A3, 32'h5555_00A4};
    for (int i = 0; i < 1024; i++) begin
      mem[i]    = 32'h5EED_0000 + 32'(i);
      refMem[i] = 32'h5EED_0000 + 32'(i);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    checkEn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    idleCycle(); sampleNow();
    checkBit("resetBusy", busy, 1'b0);
    checkBit("resetValid", instrValid, 1'b0);
    checkOutput("resetInstr", instrOut, 32'd0);
    checkOutput("resetPc", pcOut, 32'd0);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 10'(k), aWord[k]);
      sampleNow();
      checkBit("preloadGrant", loadGrant, 1'b1);
    end

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    idleCycle(); sampleNow();
    checkBit("firstBusy", busy, 1'b1);
    checkBit("firstValid", instrValid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      idleCycle(); sampleNow();
      checkOutput("seqInstr", instrOut, aWord[k]);
      checkOutput("seqPc", pcOut, 32'(4 * k));
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 10'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 10'd4, aWord[4]);
    sampleNow();
    checkBit("haltBusy", busy, 1'b0);
    checkBit("haltValid", instrValid, 1'b0);
    checkBit("haltGrant", loadGrant, 1'b1);
    checkBit("haltWrEn", bus.imemWrEn, 1'b1);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    idleCycle();
    idleCycle(); sampleNow();
    checkOutput("restartInstr", instrOut, aWord[0]);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
      sampleNow();
      checkOutput("stallInstr", instrOut, aWord[1]);
      checkOutput("stallPc", pcOut, 32'd4);
      checkBit("stallValid", instrValid, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 10'd0, 32'd0);
    sampleNow();
    checkOutput("branchCycleInstr", instrOut, aWord[1]);
    checkBit("branchCycleRdEn", bus.imemRdEn, 1'b0);
    idleCycle(); sampleNow();
    checkBit("branchBubble", instrValid, 1'b0);
    checkOutput("branchAddr", 32'(bus.imemAddr), 32'd4);
    idleCycle(); sampleNow();
    checkOutput("branchInstr", instrOut, aWord[4]);
    checkOutput("branchPc", pcOut, 32'h10);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 10'd7, 32'hDEAD_0007);
    sampleNow();
    checkBit("runLoadGrant", loadGrant, 1'b0);
    checkBit("runLoadWrEn", bus.imemWrEn, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 10'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 10'd5, 32'hBEEF_0005);
    sampleNow();
    checkBit("loadStartGrant", loadGrant, 1'b1);
    idleCycle(); sampleNow();
    checkBit("loadStartStaysIdle", busy, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0FFC, 1'b0, 1'b0, 10'd0, 32'd0);
    idleCycle(); sampleNow();
    checkOutput("wrapAddrTop", 32'(bus.imemAddr), 32'd1023);
    idleCycle(); sampleNow();
    checkOutput("wrapAddrZero", 32'(bus.imemAddr), 32'd0);
    checkOutput("wrapInstrTop", instrOut, 32'h5EED_03FF);
    checkOutput("wrapPcTop", pcOut, 32'h0000_0FFC);
    idleCycle(); sampleNow();
    checkOutput("wrapInstrZero", instrOut, aWord[0]);
    checkOutput("wrapPcNext", pcOut, 32'h0000_1000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    sampleNow();
    checkBit("midRunResetRdEn", bus.imemRdEn, 1'b0);
    idleCycle(); sampleNow();
    checkBit("midRunResetBusy", busy, 1'b0);
    checkBit("midRunResetValid", instrValid, 1'b0);
    checkOutput("midRunResetInstr", instrOut, 32'd0);
    checkOutput("midRunResetPc", pcOut, 32'd0);

    for (int c = 0; c < 4000; c++) begin
      applyStimulus($urandom_range(0, 199) != 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 9) == 0,
                    ($urandom_range(0, 1) == 0) ? $urandom : (32'h0000_0FF0 + 32'($urandom_range(0, 31))),
                    $urandom_range(0, 29) == 0,
                    $urandom_range(0, 5) == 0,
                    10'($urandom_range(0, 1023)),
                    $urandom);
    end
    idleCycle();
    sampleNow();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/imem_fetch_sequencer.md
IMEM_FETCH_SEQUENCER -- requirements
Module: imem_fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset and on Start.
REQ-002 Parameter ADDR_W, default 10: instruction-memory word-address width (1024 words).
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  synchronous, active-low reset, sampled on rising Clk.
REQ-005 Start  input  1  begin fetching from RESET_PC (honoured in IDLE/HALTED only).
REQ-006 Stall  input  1  downstream not ready; freeze fetch.
REQ-007 BranchTaken  input  1  redirect request.
REQ-008 BranchTarget  input  32  redirect byte address.
REQ-009 Halt  input  1  stop fetching after the current cycle.
REQ-010 LoadReq / LoadAddr[ADDR_W-1:0] / LoadData[31:0]  input  boot-loader write request, word address, data.
REQ-011 LoadGrant  output  1  load write accepted this cycle.
REQ-012 ImemAddr  output  ADDR_W  memory word address; ImemRdEn / ImemWrEn  output  1 each; ImemWrData  output  32.
REQ-013 ImemRdData  input  32  read data, valid one cycle after ImemRdEn.
REQ-014 InstrOut  output  32, PCOut  output  32, InstrValid  output  1: fetched instruction, its byte PC, qualifier.
REQ-015 Busy  output  1  high in RUN.

Function
REQ-016 FSM states SHALL be IDLE, RUN, HALTED; reset enters IDLE.
REQ-017 IDLE/HALTED -> RUN on Start=1 and LoadReq=0; PC<=RESET_PC.
REQ-018 RUN -> HALTED on Halt=1; the fetch issued that cycle is discarded (InstrValid=0 next cycle).
REQ-019 In RUN with Stall=0: ImemRdEn=1, ImemAddr=PC[ADDR_W+1:2], PC<=PC+4 (mod 2^32); ImemAddr wraps modulo 2^ADDR_W.
REQ-020 Latency: one cycle after an issued read, InstrOut=ImemRdData, PCOut=issued PC, InstrValid=1.
REQ-021 Stall=1 in RUN: ImemRdEn=0, PC held, InstrOut/PCOut/InstrValid held unchanged.
REQ-022 BranchTaken=1 in RUN: PC<={BranchTarget[31:2],2'b00}, ImemRdEn=0 that cycle, InstrValid=0 next cycle; fetch resumes from target the following cycle.
REQ-023 Priority in RUN: Halt > BranchTaken > Stall > sequential fetch.
REQ-024 A read already issued when Stall rises SHALL still be captured to InstrOut (one-entry hold register); no instruction lost or duplicated.
REQ-025 LoadGrant=LoadReq when state is IDLE or HALTED, else 0 (combinational); on grant ImemWrEn=1, ImemAddr=LoadAddr, ImemWrData=LoadData.
REQ-026 LoadReq has priority over Start; Start asserted with LoadReq=1 is ignored.
REQ-027 ImemRdEn and ImemWrEn SHALL never be high in the same cycle.
REQ-028 Busy=1 iff state is RUN; InstrValid=0 in IDLE and HALTED.

Reset
REQ-029 Reset_n=0 at a rising edge: state IDLE, PC=RESET_PC, InstrOut=0, PCOut=0, InstrValid=0, Busy=0; ImemRdEn, ImemWrEn, LoadGrant=0 combinationally while Reset_n=0.
REQ-030 Reset mid-RUN or mid-load SHALL abandon the operation with no further memory access that cycle.

Verification
REQ-031 Preload words 0..3 = A0,A1,A2,A3 via load port; Start -> InstrOut A0,A1,A2,A3 on consecutive cycles with PCOut 0,4,8,12.
REQ-032 Stall held 3 cycles after 2nd fetch -> InstrOut=A1, PCOut=4, InstrValid=1 held 3 cycles, then A2 at PCOut=8; no skip/duplicate.
REQ-033 BranchTaken with BranchTarget=0x0000_0013 at PC=8 -> one InstrValid=0 cycle, then PCOut=0x10, InstrOut=word 4.
REQ-034 Halt and BranchTaken same cycle -> HALTED, Busy=0, InstrValid=0; LoadReq then granted immediately.
REQ-035 LoadReq in RUN -> LoadGrant=0, ImemWrEn=0 throughout; LoadReq+Start in IDLE -> write occurs, state stays IDLE.
REQ-036 RESET_PC=0xFFC, ADDR_W=10 -> ImemAddr 1023 then 0, PCOut 0xFFC then 0x1000; Reset_n=0 mid-run -> all outputs at REQ-029 values next edge.
